// File: rtl/ps_cu_issue_if.sv
// Instruction-word handshake between the sequencer and the CU issue stage.
interface ps_cu_issue_if #(
  parameter int INSTR_WIDTH = 24
) ();
  logic                   instr_valid;
  logic                   instr_ready;
  logic [INSTR_WIDTH-1:0] instr;

  modport master (output instr_valid, output instr, input instr_ready);
  modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/ps_cu_issue.sv
// ps_cu_issue: CU issue stage -- decode, E/W scheduling, RAW stall, ASTAT collection.
// Define PS_CU_BCWRITE_EN to turn unit code 11 into a bus-connect RF write (else a NOP).
module ps_cu_issue #(
  parameter int RF_DATASIZE   = 16,
  parameter int ADDRESS_WIDTH = 4,
  parameter int SIGNAL_WIDTH  = 3,
  parameter int INSTR_WIDTH   = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  ps_cu_issue_if.slave             instr_if,
  output logic [ADDRESS_WIDTH-1:0] ps_xb_raddx,
  output logic [ADDRESS_WIDTH-1:0] ps_xb_raddy,
  output logic [ADDRESS_WIDTH-1:0] ps_xb_wadd,
  output logic [SIGNAL_WIDTH-1:0]  ps_xb_w_cuEn,
  output logic                     ps_xb_w_bcEn,
  output logic                     ps_alu_en,
  output logic                     ps_alu_log,
  output logic                     ps_alu_sat,
  output logic [1:0]               ps_alu_hc,
  output logic [2:0]               ps_alu_sc,
  output logic                     ps_mul_en,
  output logic                     ps_mul_otreg,
  output logic [3:0]               ps_mul_dtsts,
  output logic [1:0]               ps_mul_cls,
  output logic                     ps_shf_en,
  output logic [1:0]               ps_shf_cls,
  input  logic                     alu_ps_az,
  input  logic                     alu_ps_an,
  input  logic                     alu_ps_ac,
  input  logic                     alu_ps_av,
  input  logic                     mul_ps_ov,
  input  logic                     mul_ps_mn,
  input  logic                     shf_ps_sv,
  input  logic                     shf_ps_sz,
  output logic [7:0]               astat,
  output logic                     illegal,
  output logic                     busy
);
  localparam int AW = ADDRESS_WIDTH;

  if (INSTR_WIDTH != 12 + 3 * AW || RF_DATASIZE < 1) begin : g_param_check
    $error("ps_cu_issue: INSTR_WIDTH must equal 12+3*ADDRESS_WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WB      = 2'b01,
    EXEC    = 2'b10,
    EXEC_WB = 2'b11
  } state_t;

  state_t          r_state;
  logic [1:0]      r_e_unit;
  logic [1:0]      r_w_unit;
  logic [AW-1:0]   r_e_rd;

  logic [1:0]      w_unit;
  logic [9:0]      w_ctl;
  logic [AW-1:0]   w_rd, w_rx, w_ry;
  logic            w_e_valid, w_w_valid, w_w_next, w_e_writes;
  logic            w_hazard, w_bc_conflict, w_accept;
  logic            w_unused_ctl;

  assign {w_unit, w_ctl, w_rd, w_rx, w_ry} = instr_if.instr;
  assign w_unused_ctl = ^w_ctl[9:7];

  assign w_e_valid = (r_state == EXEC) || (r_state == EXEC_WB);
  assign w_w_valid = (r_state == WB)   || (r_state == EXEC_WB);
  assign w_w_next  = w_e_valid && (r_e_unit != 2'b11);

`ifdef PS_CU_BCWRITE_EN
  // A bc load writes wadd in its E cycle, so it must not meet a W-stage write.
  assign w_e_writes    = w_e_valid;
  assign w_bc_conflict = (w_unit == 2'b11) && w_w_next;
`else
  assign w_e_writes    = w_w_next;
  assign w_bc_conflict = 1'b0;
`endif

  assign w_hazard = w_e_writes && ((w_rx == r_e_rd) || (w_ry == r_e_rd));
  assign instr_if.instr_ready = !reset && !w_hazard && !w_bc_conflict;
  assign w_accept = instr_if.instr_valid && instr_if.instr_ready;
  assign busy     = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_e_unit     <= '0;
      r_w_unit     <= '0;
      r_e_rd       <= '0;
      ps_xb_raddx  <= '0;
      ps_xb_raddy  <= '0;
      ps_xb_wadd   <= '0;
      ps_xb_w_cuEn <= '0;
      ps_xb_w_bcEn <= 1'b0;
      ps_alu_en    <= 1'b0;
      ps_alu_log   <= 1'b0;
      ps_alu_sat   <= 1'b0;
      ps_alu_hc    <= '0;
      ps_alu_sc    <= '0;
      ps_mul_en    <= 1'b0;
      ps_mul_otreg <= 1'b0;
      ps_mul_dtsts <= '0;
      ps_mul_cls   <= '0;
      ps_shf_en    <= 1'b0;
      ps_shf_cls   <= '0;
      astat        <= '0;
      illegal      <= 1'b0;
    end else begin
      unique case ({w_accept, w_w_next})
        2'b00:   r_state <= IDLE;
        2'b01:   r_state <= WB;
        2'b10:   r_state <= EXEC;
        default: r_state <= EXEC_WB;
      endcase

      ps_alu_en    <= 1'b0;
      ps_alu_log   <= 1'b0;
      ps_alu_sat   <= 1'b0;
      ps_alu_hc    <= '0;
      ps_alu_sc    <= '0;
      ps_mul_en    <= 1'b0;
      ps_mul_otreg <= 1'b0;
      ps_mul_dtsts <= '0;
      ps_mul_cls   <= '0;
      ps_shf_en    <= 1'b0;
      ps_shf_cls   <= '0;
      ps_xb_w_bcEn <= 1'b0;
      illegal      <= 1'b0;
      ps_xb_w_cuEn <= '0;

      if (w_accept) begin
        r_e_unit    <= w_unit;
        r_e_rd      <= w_rd;
        ps_xb_raddx <= w_rx;
        ps_xb_raddy <= w_ry;
        unique case (w_unit)
          2'b00: begin
            ps_alu_en  <= 1'b1;
            ps_alu_log <= w_ctl[0];
            ps_alu_hc  <= w_ctl[2:1];
            ps_alu_sc  <= w_ctl[5:3];
            ps_alu_sat <= w_ctl[6];
          end
          2'b01: begin
            ps_mul_en    <= 1'b1;
            ps_mul_otreg <= w_ctl[0];
            ps_mul_dtsts <= w_ctl[4:1];
            ps_mul_cls   <= w_ctl[6:5];
          end
          2'b10: begin
            ps_shf_en  <= 1'b1;
            ps_shf_cls <= w_ctl[1:0];
          end
          default: begin
`ifdef PS_CU_BCWRITE_EN
            ps_xb_w_bcEn <= 1'b1;
            ps_xb_wadd   <= w_rd;
`else
            illegal      <= 1'b1;
`endif
          end
        endcase
      end

      if (w_w_next) begin
        ps_xb_w_cuEn <= SIGNAL_WIDTH'(1) << r_e_unit;
        ps_xb_wadd   <= r_e_rd;
        r_w_unit     <= r_e_unit;
      end

      if (w_w_valid) begin
        unique case (r_w_unit)
          2'b00:   astat[3:0] <= {alu_ps_av, alu_ps_ac, alu_ps_an, alu_ps_az};
          2'b01:   astat[5:4] <= {mul_ps_mn, mul_ps_ov};
          default: astat[7:6] <= {shf_ps_sz, shf_ps_sv};
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ps_cu_issue.sv
// Scoreboard bench for ps_cu_issue: driver predicts handshake and pushes timed E/W events; monitor checks them.
module tb_ps_cu_issue;
  localparam int AW = 4;
  localparam int IW = 24;
  localparam int SW = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ps_cu_issue_if #(.INSTR_WIDTH(IW)) instr_if ();

  logic [AW-1:0] raddx, raddy, wadd;
  logic [SW-1:0] w_cuen;
  logic          bcen, alu_en, alu_log, alu_sat, mul_en, mul_otreg, shf_en;
  logic [1:0]    alu_hc, mul_cls, shf_cls;
  logic [2:0]    alu_sc;
  logic [3:0]    mul_dtsts;
  logic [7:0]    astat;
  logic          illegal, busy;
  logic          az, an, ac, av, ov, mn, sv, sz;
  logic [7:0]    flags = '0;
  assign {sz, sv, mn, ov, av, ac, an, az} = flags;

  ps_cu_issue #(
    .RF_DATASIZE(16), .ADDRESS_WIDTH(AW), .SIGNAL_WIDTH(SW), .INSTR_WIDTH(IW)
  ) dut (
    .clk(clk), .reset(reset), .instr_if(instr_if.slave),
    .ps_xb_raddx(raddx), .ps_xb_raddy(raddy), .ps_xb_wadd(wadd),
    .ps_xb_w_cuEn(w_cuen), .ps_xb_w_bcEn(bcen),
    .ps_alu_en(alu_en), .ps_alu_log(alu_log), .ps_alu_sat(alu_sat),
    .ps_alu_hc(alu_hc), .ps_alu_sc(alu_sc),
    .ps_mul_en(mul_en), .ps_mul_otreg(mul_otreg), .ps_mul_dtsts(mul_dtsts), .ps_mul_cls(mul_cls),
    .ps_shf_en(shf_en), .ps_shf_cls(shf_cls),
    .alu_ps_az(az), .alu_ps_an(an), .alu_ps_ac(ac), .alu_ps_av(av),
    .mul_ps_ov(ov), .mul_ps_mn(mn), .shf_ps_sv(sv), .shf_ps_sz(sz),
    .astat(astat), .illegal(illegal), .busy(busy)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [1:0] unit;
    logic [9:0] ctl;
    logic [3:0] rd, rx, ry;
  } ent_t;

  ent_t       qE[$];
  ent_t       qW[$];
  logic [7:0] astat_m = '0;
  bit         mon_en = 1'b0;

  // Instruction currently sitting in E, as the driver's model sees it.
  bit         occ_v = 1'b0;
  logic [1:0] occ_unit = '0;
  logic [3:0] occ_rd = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [23:0] mk(input logic [1:0] u, input logic [9:0] c,
                                     input logic [3:0] d, input logic [3:0] x, input logic [3:0] y);
    return {u, c, d, x, y};
  endfunction

  function automatic bit occ_writes_rf();
`ifdef PS_CU_BCWRITE_EN
    return occ_v;
`else
    return occ_v && (occ_unit != 2'b11);
`endif
  endfunction

  // Caller is positioned just after a rising edge; returns just after the next one.
  task automatic issue(input bit v, input logic [23:0] word, input logic [7:0] fl,
                       output bit acc, output bit rdy_seen);
    logic [1:0] u;
    logic [3:0] rd, rx, ry;
    bit haz, bcc, exp_rdy;
    instr_if.instr_valid = v;
    instr_if.instr       = word;
    flags                = fl;
    u  = word[23:22];
    rd = word[11:8];
    rx = word[7:4];
    ry = word[3:0];
    haz = occ_writes_rf() && (rx == occ_rd || ry == occ_rd);
    bcc = 1'b0;
`ifdef PS_CU_BCWRITE_EN
    bcc = (u == 2'b11) && occ_v && (occ_unit != 2'b11);
`endif
    exp_rdy = !haz && !bcc;
    @(negedge clk);
    chk("instr_ready", instr_if.instr_ready, exp_rdy);
    rdy_seen = instr_if.instr_ready;
    acc = v && exp_rdy;
    if (acc) begin
      qE.push_back('{cyc + 1, u, word[21:12], rd, rx, ry});
      if (u != 2'b11) qW.push_back('{cyc + 2, u, word[21:12], rd, rx, ry});
    end
    occ_v    = acc;
    occ_unit = u;
    occ_rd   = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [23:0] word, input logic [7:0] fl, output int stalls);
    bit acc, rs;
    stalls = 0;
    for (int n = 0; n < 8; n++) begin
      issue(1'b1, word, fl, acc, rs);
      if (!rs) stalls++;
      if (acc) return;
    end
    checks++;
    failures++;
    $display("FAIL send_timeout cyc=%0d actual=not_accepted expected=accepted", cyc);
  endtask

  task automatic idle(input int n, input logic [7:0] fl);
    bit acc, rs;
    for (int i = 0; i < n; i++) issue(1'b0, 24'($urandom), fl, acc, rs);
  endtask

  task automatic check_e(input ent_t e);
    logic [4:0] en_exp;
    case (e.unit)
      2'b00:   en_exp = 5'b10000;
      2'b01:   en_exp = 5'b01000;
      2'b10:   en_exp = 5'b00100;
`ifdef PS_CU_BCWRITE_EN
      default: en_exp = 5'b00001;
`else
      default: en_exp = 5'b00010;
`endif
    endcase
    chk("e_enables", {alu_en, mul_en, shf_en, illegal, bcen}, en_exp);
    chk("e_raddr", {raddx, raddy}, {e.rx, e.ry});
    case (e.unit)
      2'b00: chk("alu_ctl", {alu_log, alu_hc, alu_sc, alu_sat},
                 {e.ctl[0], e.ctl[2:1], e.ctl[5:3], e.ctl[6]});
      2'b01: chk("mul_ctl", {mul_otreg, mul_dtsts, mul_cls}, {e.ctl[0], e.ctl[4:1], e.ctl[6:5]});
      2'b10: chk("shf_ctl", shf_cls, e.ctl[1:0]);
      default: begin
`ifdef PS_CU_BCWRITE_EN
        chk("bc_wadd", wadd, e.rd);
`endif
      end
    endcase
  endtask

  always @(negedge clk) begin : monitor
    bit         e_due, w_due;
    ent_t       e, w;
    logic [2:0] oh;
    if (mon_en) begin
      e_due = (qE.size() > 0) && (qE[0].cyc == cyc);
      w_due = (qW.size() > 0) && (qW[0].cyc == cyc);
      chk("busy", busy, e_due || w_due);
      chk("astat", astat, astat_m);
      if (e_due) begin
        e = qE.pop_front();
        check_e(e);
      end else begin
        chk("e_idle", {alu_en, mul_en, shf_en, illegal, bcen}, 5'b0);
      end
      if (w_due) begin
        w  = qW.pop_front();
        oh = 3'b001 << w.unit;
        chk("w_stage", {w_cuen, wadd}, {oh, w.rd});
        case (w.unit)
          2'b00:   astat_m[3:0] = flags[3:0];
          2'b01:   astat_m[5:4] = flags[5:4];
          default: astat_m[7:6] = flags[7:6];
        endcase
      end else begin
        chk("w_idle", w_cuen, 3'b000);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int st, s1, s2, s3;
    bit acc, rs;
    instr_if.instr_valid = 1'b1;
    instr_if.instr       = mk(2'b00, 10'h049, 4'd3, 4'd1, 4'd2);
    repeat (3) @(negedge clk);
    chk("rst_outputs", {raddx, raddy, wadd, w_cuen, bcen, alu_en, alu_log, alu_sat, alu_hc, alu_sc,
                        mul_en, mul_otreg, mul_dtsts, mul_cls, shf_en, shf_cls, astat, illegal, busy},
        '0);
    chk("rst_ready", instr_if.instr_ready, 1'b0);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    // ALU word accepted on the first edge after release; az=1 lands in astat.
    send(mk(2'b00, 10'h049, 4'd3, 4'd1, 4'd2), 8'h00, st);
    chk("first_accept_stalls", st, 0);
    idle(3, 8'h01);
    chk("astat_alu_az", astat, 8'h01);

    send(mk(2'b01, 10'h015, 4'd5, 4'd0, 4'd1), 8'h30, st);
    send(mk(2'b00, 10'h002, 4'd6, 4'd5, 4'd2), 8'h0c, st);
    chk("raw_stall_cycles", st, 1);
    idle(3, $urandom);

    send(mk(2'b00, 10'h07f, 4'd1, 4'd2, 4'd3), $urandom, s1);
    send(mk(2'b01, 10'h06a, 4'd4, 4'd5, 4'd6), $urandom, s2);
    send(mk(2'b10, 10'h002, 4'd7, 4'd8, 4'd9), $urandom, s3);
    chk("stream_stalls", s1 + s2 + s3, 0);
    idle(3, $urandom);

    send(mk(2'b10, 10'h001, 4'd2, 4'd0, 4'd1), $urandom, st);
    send(mk(2'b11, 10'h000, 4'd7, 4'd10, 4'd11), $urandom, st);
`ifdef PS_CU_BCWRITE_EN
    chk("bc_stall_cycles", st, 1);
`else
    chk("nop_stall_cycles", st, 0);
`endif
    idle(3, $urandom);

    // Reset while a MUL sits in E: no write-back, astat cleared.
    send(mk(2'b01, 10'h3ff, 4'd9, 4'd8, 4'd7), 8'hff, st);
    reset  = 1'b1;
    mon_en = 1'b0;
    instr_if.instr_valid = 1'b0;
    qE.delete();
    qW.delete();
    @(negedge clk);
    chk("mul_in_e_before_reset", mul_en, 1'b1);
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_writeback", {w_cuen, busy}, 4'b0000);
      chk("rst_astat", astat, 8'h00);
    end
    @(posedge clk);
    #1;
    reset   = 1'b0;
    occ_v   = 1'b0;
    astat_m = '0;
    mon_en  = 1'b1;

    for (int n = 0; n < 400; n++) begin
      issue($urandom_range(0, 9) < 8,
            mk(2'($urandom), 10'($urandom), 4'($urandom_range(0, 5)),
               4'($urandom_range(0, 5)), 4'($urandom_range(0, 5))),
            8'($urandom), acc, rs);
    end
    idle(4, $urandom);
    chk("drain_empty", qE.size() + qW.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
